// File: rtl/mult_div_unit.sv
// Multi-cycle multiply/divide unit holding the architectural HI/LO registers.
// Operands are latched on accept; the result is committed to HI/LO on the last busy cycle.
module mult_div_unit #(
    parameter int unsigned MUL_CYCLES = 5,
    parameter int unsigned DIV_CYCLES = 10
) (
    input  logic        clk,
    input  logic        Reset,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic        Start,
    input  logic [2:0]  MDOp,
    output logic        Busy,
    output logic        Done,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    typedef enum logic {StIdle, StRun} state_e;

    state_e      state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [2:0]  op_q, op_d;
    logic [31:0] a_q, a_d, b_q, b_d;
    logic [31:0] hi_q, hi_d, lo_q, lo_d;
    logic        done_q, done_d;

    logic        is_signed, is_div, a_neg, b_neg;
    logic [63:0] mul_a, mul_b, prod;
    logic [31:0] a_mag, b_mag, divisor, q_mag, r_mag, quot, rem;

    // Op codes 0/2 are signed, 1/3 unsigned; bit 1 selects divide.
    assign is_signed = ~op_q[0];
    assign is_div    = op_q[1];

    assign mul_a = is_signed ? {{32{a_q[31]}}, a_q} : {32'b0, a_q};
    assign mul_b = is_signed ? {{32{b_q[31]}}, b_q} : {32'b0, b_q};
    assign prod  = mul_a * mul_b;

    // Sign-magnitude divide: quotient truncates toward zero, remainder follows the dividend.
    assign a_neg   = is_signed & a_q[31];
    assign b_neg   = is_signed & b_q[31];
    assign a_mag   = a_neg ? (~a_q + 32'd1) : a_q;
    assign b_mag   = b_neg ? (~b_q + 32'd1) : b_q;
    assign divisor = (b_mag == 32'd0) ? 32'd1 : b_mag;
    assign q_mag   = a_mag / divisor;
    assign r_mag   = a_mag % divisor;
    assign quot    = (a_neg ^ b_neg) ? (~q_mag + 32'd1) : q_mag;
    assign rem     = a_neg ? (~r_mag + 32'd1) : r_mag;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        done_d  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (Start) begin
                    case (MDOp)
                        3'd0, 3'd1, 3'd2, 3'd3: begin
                            op_d    = MDOp;
                            a_d     = A;
                            b_d     = B;
                            cnt_d   = MDOp[1] ? 5'(DIV_CYCLES - 1) : 5'(MUL_CYCLES - 1);
                            state_d = StRun;
                        end
                        3'd4:    hi_d = A;
                        3'd5:    lo_d = A;
                        default: ;
                    endcase
                end
            end
            StRun: begin
                if (cnt_q == 5'd0) begin
                    state_d = StIdle;
                    done_d  = 1'b1;
                    if (!is_div) begin
                        hi_d = prod[63:32];
                        lo_d = prod[31:0];
                    end else if (b_q != 32'd0) begin
                        hi_d = rem;
                        lo_d = quot;
                    end
                end else begin
                    cnt_d = cnt_q - 5'd1;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (Reset) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            done_q  <= done_d;
        end
    end

    assign Busy = (state_q == StRun);
    assign Done = done_q;
    assign HI   = hi_q;
    assign LO   = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Bench for mult_div_unit: cycle-level reference model compared every cycle,
// plus hand-computed expectations for the directed vectors.
module tb_mult_div_unit;

    localparam int MUL_N = 5;
    localparam int DIV_N = 10;

    logic        clk;
    logic        Reset;
    logic [31:0] A, B;
    logic        Start;
    logic [2:0]  MDOp;
    logic        Busy, Done;
    logic [31:0] HI, LO;

    int checks = 0;
    int errors = 0;
    bit chk_en = 0;

    mult_div_unit #(
        .MUL_CYCLES(MUL_N),
        .DIV_CYCLES(DIV_N)
    ) dut (
        .clk  (clk),
        .Reset(Reset),
        .A    (A),
        .B    (B),
        .Start(Start),
        .MDOp (MDOp),
        .Busy (Busy),
        .Done (Done),
        .HI   (HI),
        .LO   (LO)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference result as {HI, LO}, from plain 64-bit arithmetic.
    function automatic logic [63:0] model_result(input logic [2:0] op, input logic [31:0] a,
                                                 input logic [31:0] b);
        longint          sa, sb, sq, sr;
        longint unsigned ua, ub;
        logic [63:0]     r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'b0, a};
        ub = {32'b0, b};
        r  = '0;
        case (op)
            3'd0: r = sa * sb;
            3'd1: r = ua * ub;
            3'd2: if (b != 0) begin
                sq = sa / sb;
                sr = sa % sb;
                r  = {sr[31:0], sq[31:0]};
            end
            3'd3: if (b != 0) begin
                r = {32'(ua % ub), 32'(ua / ub)};
            end
            default: r = '0;
        endcase
        return r;
    endfunction

    int          m_left;
    logic [31:0] m_hi, m_lo;
    logic        m_done, m_pend_ok;
    logic [63:0] m_pend;

    always @(posedge clk) begin
        if (Reset) begin
            m_left    <= 0;
            m_hi      <= '0;
            m_lo      <= '0;
            m_done    <= 1'b0;
            m_pend_ok <= 1'b0;
            m_pend    <= '0;
        end else begin
            m_done <= 1'b0;
            if (m_left > 0) begin
                m_left <= m_left - 1;
                if (m_left == 1) begin
                    m_done <= 1'b1;
                    if (m_pend_ok) begin
                        m_hi <= m_pend[63:32];
                        m_lo <= m_pend[31:0];
                    end
                end
            end else if (Start) begin
                if (MDOp < 3'd4) begin
                    m_left    <= (MDOp < 3'd2) ? MUL_N : DIV_N;
                    m_pend    <= model_result(MDOp, A, B);
                    m_pend_ok <= !(MDOp >= 3'd2 && B == 32'd0);
                end else if (MDOp == 3'd4) begin
                    m_hi <= A;
                end else if (MDOp == 3'd5) begin
                    m_lo <= A;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            checks++;
            if (Busy !== (m_left != 0) || Done !== m_done || HI !== m_hi || LO !== m_lo) begin
                errors++;
                $display("FAIL cycle t=%0t busy=%b exp %b done=%b exp %b hi=%h exp %h lo=%h exp %h",
                         $time, Busy, (m_left != 0), Done, m_done, HI, m_hi, LO, m_lo);
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic s, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b);
        @(negedge clk);
        Start = s;
        MDOp  = op;
        A     = a;
        B     = b;
    endtask

    // Issue one op, scramble operands after accept, and count Busy/Done cycles.
    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input int n, output int bc, output int dc);
        drive(1'b1, op, a, b);
        @(negedge clk);
        Start = 1'b0;
        A     = ~a;
        B     = ~b;
        bc    = int'(Busy);
        dc    = int'(Done);
        repeat (n + 3) begin
            @(negedge clk);
            bc += int'(Busy);
            dc += int'(Done);
        end
    endtask

    task automatic wait_idle();
        int n = 0;
        while (Busy && n < 50) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (Busy) begin
            errors++;
            $display("FAIL wait_idle busy=%b expected 0 after %0d cycles", Busy, n);
        end
    endtask

    initial begin
        int bc, dc;
        // Reset and Start together: the MTHI must be dropped.
        Reset = 1'b1;
        Start = 1'b1;
        MDOp  = 3'd4;
        A     = 32'h0000_0123;
        B     = '0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_busy", {31'b0, Busy}, 32'd0);
        chk("rst_done", {31'b0, Done}, 32'd0);
        chk("rst_hi", HI, 32'd0);
        chk("rst_lo", LO, 32'd0);
        Reset  = 1'b0;
        Start  = 1'b0;
        chk_en = 1'b1;

        run_op(3'd0, 32'hFFFF_FFFE, 32'd3, MUL_N, bc, dc);
        chk("mult_busy_cycles", 32'(bc), 32'd5);
        chk("mult_done_pulses", 32'(dc), 32'd1);
        chk("mult_hi", HI, 32'hFFFF_FFFF);
        chk("mult_lo", LO, 32'hFFFF_FFFA);

        run_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, MUL_N, bc, dc);
        chk("multu_hi", HI, 32'hFFFF_FFFE);
        chk("multu_lo", LO, 32'h0000_0001);

        run_op(3'd2, 32'hFFFF_FFF9, 32'd2, DIV_N, bc, dc);
        chk("div_busy_cycles", 32'(bc), 32'd10);
        chk("div_lo", LO, 32'hFFFF_FFFD);
        chk("div_hi", HI, 32'hFFFF_FFFF);

        run_op(3'd3, 32'd7, 32'd2, DIV_N, bc, dc);
        chk("divu_lo", LO, 32'd3);
        chk("divu_hi", HI, 32'd1);

        run_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, DIV_N, bc, dc);
        chk("divovf_lo", LO, 32'h8000_0000);
        chk("divovf_hi", HI, 32'd0);

        drive(1'b1, 3'd4, 32'h1111_1111, 32'd0);
        drive(1'b1, 3'd5, 32'h2222_2222, 32'd0);
        drive(1'b0, 3'd0, 32'd0, 32'd0);
        chk("mthi", HI, 32'h1111_1111);
        chk("mtlo", LO, 32'h2222_2222);
        run_op(3'd3, 32'd5, 32'd0, DIV_N, bc, dc);
        chk("div0_busy_cycles", 32'(bc), 32'd10);
        chk("div0_done_pulses", 32'(dc), 32'd1);
        chk("div0_hi", HI, 32'h1111_1111);
        chk("div0_lo", LO, 32'h2222_2222);

        // Requests during Busy are ignored; operands change after accept.
        drive(1'b1, 3'd0, 32'd2, 32'd3);
        drive(1'b1, 3'd4, 32'h0000_DEAD, 32'd0);
        drive(1'b1, 3'd2, 32'd7, 32'd9);
        chk("busy_mthi_ignored", HI, 32'h1111_1111);
        drive(1'b0, 3'd0, 32'd55, 32'd66);
        wait_idle();
        chk("rej_done", {31'b0, Done}, 32'd1);
        chk("rej_hi", HI, 32'd0);
        chk("rej_lo", LO, 32'd6);
        Start = 1'b1;
        MDOp  = 3'd4;
        A     = 32'h0000_DEAD;
        @(negedge clk);
        Start = 1'b0;
        chk("mthi_after_done", HI, 32'h0000_DEAD);

        // Reset during the third busy cycle of a DIV aborts it.
        drive(1'b1, 3'd2, 32'd100, 32'd7);
        drive(1'b0, 3'd0, 32'd0, 32'd0);
        @(negedge clk);
        @(negedge clk);
        Reset = 1'b1;
        @(negedge clk);
        Reset = 1'b0;
        chk("abort_busy", {31'b0, Busy}, 32'd0);
        chk("abort_hi", HI, 32'd0);
        chk("abort_lo", LO, 32'd0);
        dc = 0;
        repeat (15) begin
            @(negedge clk);
            dc += int'(Done);
        end
        chk("abort_no_done", 32'(dc), 32'd0);

        run_op(3'd0, 32'd4, 32'd5, MUL_N, bc, dc);
        chk("post_mult_busy", 32'(bc), 32'd5);
        chk("post_mult_done", 32'(dc), 32'd1);
        chk("post_mult_lo", LO, 32'd20);
        chk("post_mult_hi", HI, 32'd0);

        chk_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mult_div_unit.md
# mult_div_unit

Multi-cycle multiply/divide unit with architectural HI/LO registers for the MIPS pipeline. It sits in the execute stage directly downstream of the general register file. It consumes the two register read operands, after forwarding, and holds the products and quotients that MFHI/MFLO later return. Busy drives the hazard unit's stall of MDU-class instructions.

## Interface
Parameters:
- MUL_CYCLES, default 5: Busy cycles for MULT/MULTU; legal range 1..31.
- DIV_CYCLES, default 10: Busy cycles for DIV/DIVU; legal range 1..31.

Ports:
- clk, input, 1: single clock; all state updates on the rising edge.
- Reset, input, 1: synchronous, active-high; clears all state on the edge at which it is sampled high.
- A, input, 32: operand 1 (rs value).
- B, input, 32: operand 2 (rt value).
- Start, input, 1: request strobe, qualified by MDOp.
- MDOp, input, 3: operation code.
  - 0: MULT
  - 1: MULTU
  - 2: DIV
  - 3: DIVU
  - 4: MTHI
  - 5: MTLO
  - 6-7: no-op
- Busy, output, 1: an operation is in flight.
- Done, output, 1: one-cycle pulse in the cycle after HI/LO are committed.
- HI, output, 32: HI register.
- LO, output, 32: LO register.

## Operation
- State machine:
  - IDLE: waits for a request.
  - RUN: a down-counter is loaded with the latency and decrements every cycle.
- Accept in IDLE: when Start=1 and MDOp is 0-3, A, B and MDOp are latched on that edge and the FSM enters RUN.
- Commit: when the counter reaches its final cycle, HI/LO are written and the FSM returns to IDLE.
- MTHI/MTLO: in IDLE, Start=1 with MDOp=4 writes HI<=A, and MDOp=5 writes LO<=A, on that edge. Busy is not asserted.
- Ignored requests: Start is ignored entirely while Busy=1, for all ops including MTHI/MTLO. MDOp 6-7 is ignored.
- Multiply:
  - MULT forms the signed 64-bit product of A and B; MULTU forms the unsigned product.
  - {HI,LO} = product.
- Divide:
  - LO = quotient, truncated toward zero.
  - HI = remainder, which carries the sign of the dividend A.
  - Signed overflow case 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0.
- Divide by zero (B=0, DIV or DIVU):
  - The full DIV_CYCLES Busy period still elapses.
  - HI and LO keep their prior values.
  - Done still pulses.
- Operand stability: A and B may change freely after the accept edge. The result depends only on the latched values.
- Internal structure is an implementation choice: an iterative radix-2 divider and a product register are both fine, as long as the externally visible timing below holds exactly.

## Timing
- Reset values: Busy=0, Done=0, HI=0, LO=0, counter=0, FSM=IDLE.
- Reset mid-operation aborts the operation. The next cycle shows IDLE with HI=LO=0, and the result is never committed.
- Accept at edge k, with N = MUL_CYCLES or DIV_CYCLES:
  - Busy=1 during cycles k+1 through k+N.
  - HI/LO take the result at edge k+N.
  - Busy=0 and Done=1 in cycle k+N+1.
- HI/LO hold their old values throughout the Busy period; no partial results are visible.
- Back-to-back: a Start in cycle k+N+1, where Done=1 and Busy=0, is accepted. Peak throughput is therefore one operation per N+1 cycles.
- MTHI/MTLO latency: HI/LO are visible one cycle after the accept edge.
- Simultaneous Reset and Start: Reset wins and the request is dropped.
- HI and LO are registered outputs with no combinational path from A, B or MDOp.

## Test plan
- MULT: A=0xFFFFFFFE, B=3 → Busy high exactly 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFA, and Done pulses once.
- MULTU: A=B=0xFFFFFFFF → HI=0xFFFFFFFE, LO=0x00000001.
- DIV: A=0xFFFFFFF9 (−7), B=2 → after 10 Busy cycles LO=0xFFFFFFFD, HI=0xFFFFFFFF.
  - Then DIVU with A=7, B=2 → LO=3, HI=1.
  - Then DIV with A=0x80000000, B=0xFFFFFFFF → LO=0x80000000, HI=0.
- Divide by zero: preload HI=0x11111111 and LO=0x22222222 via MTHI/MTLO. Then DIVU with B=0 → Busy for 10 cycles, HI and LO unchanged, Done pulses.
- Busy-period request rejection and operand stability, starting MULT with A=2, B=3:
  - Mid-Busy, assert Start with MDOp=4 and A=0xDEAD → HI unchanged.
  - Assert Start with MDOp=2 → ignored.
  - Change A and B during Busy → final HI=0, LO=6.
  - Immediately afterwards in IDLE, MTHI A=0xDEAD → HI=0xDEAD on the next cycle.
- Reset abort: assert Reset during the 3rd Busy cycle of a DIV → next cycle Busy=0, HI=LO=0, and no Done pulse.
  - A subsequent MULT with A=4, B=5 → LO=20 with the normal 5-cycle timing.
